// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard FSM states,
// default data-wait watchdog limit.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALT,
        ERR
    } hazard_state_t;

    localparam int HAZ_WD_LIMIT_DEF = 1024;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall / redirect-flush event counters for hazard_ctrl.
// Only instantiated when HAZ_PERF_EN is defined.
module hazard_perf_cnt (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam logic [31:0] SAT = 32'hFFFF_FFFF;

    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_i && stall_q != SAT) stall_d = stall_q + 32'd1;
        if (flush_i && flush_q != SAT) flush_d = flush_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline latch/PC control: load-use, redirect, memory waits, halt, watchdog.
// Define HAZ_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WD_LIMIT = HAZ_WD_LIMIT_DEF,
    parameter int WD_W     = 11
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  regbits_t    id_rs,
    input  regbits_t    id_rt,
    input  logic        id_uses_rt,
    input  logic        idex_dREN,
    input  logic        idex_RegWr,
    input  regbits_t    idex_wsel,
    input  logic        ex_redirect,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        exmem_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        memwb_flush,
    output logic        halted,
    output logic        wd_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    hazard_state_t   state_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            halted_q;
    logic            wd_err_q;
    logic            mem_busy;
    logic            load_use;
    logic            active;

    assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign load_use = idex_dREN & idex_RegWr & (idex_wsel != '0)
                    & ((idex_wsel == id_rs)
                    | (id_uses_rt & (idex_wsel == id_rt)));
    assign active   = ~RST & ((state_q == RUN) | (state_q == DWAIT));

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (active) begin
            if (mem_busy) begin
                pc_en = 1'b0;
            end else if (exmem_halt) begin
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (ex_redirect) begin
                // Outranks load-use: the stalled ID op dies anyway.
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (load_use) begin
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (!ihit) begin
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            wd_cnt_q <= '0;
            halted_q <= 1'b0;
            wd_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        state_q <= DWAIT;
                    end else if (exmem_halt) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                DWAIT: begin
                    if (mem_busy) begin
                        if (wd_cnt_q == WD_W'(WD_LIMIT - 1)) begin
                            state_q  <= ERR;
                            halted_q <= 1'b1;
                            wd_err_q <= 1'b1;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + 1'b1;
                        end
                    end else begin
                        wd_cnt_q <= '0;
                        if (exmem_halt) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign halted = halted_q & ~RST;
    assign wd_err = wd_err_q & ~RST;

`ifdef HAZ_PERF_EN
    logic perf_stall;
    logic perf_flush;

    assign perf_stall = active & ~pc_en;
    assign perf_flush = active & ~mem_busy & ~exmem_halt & ex_redirect;

    hazard_perf_cnt u_perf (
        .CLK         (CLK),
        .RST         (RST),
        .stall_i     (perf_stall),
        .flush_i     (perf_flush),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
